// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_pkg.sv
// Shared definitions for the synchronizing debounce filter: state encoding,
// parameter legality limits and small elaboration-time helpers.
package gf180mcu_fd_sc_mcu7t5v0__dbnc_pkg;

    localparam logic STABLE   = 1'b0;
    localparam logic QUAL     = 1'b1;

    localparam int   SYNC_MIN = 2;
    localparam int   SYNC_MAX = 4;
    localparam int   FILT_MAX = 255;

    typedef enum logic {
        ST_STABLE = STABLE,
        ST_QUAL   = QUAL
    } dbnc_state_e;

    function automatic int clamp_range(input int val, input int lo, input int hi);
        if (val < lo) begin
            clamp_range = lo;
        end else if (val > hi) begin
            clamp_range = hi;
        end else begin
            clamp_range = val;
        end
    endfunction

    // Qualification counter must hold FILT_LEN-1; never narrower than one bit.
    function automatic int cnt_width(input int filt_len);
        cnt_width = (filt_len > 1) ? $clog2(filt_len) : 1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_sync.sv
// Reset-able multi-flop synchronizer bringing the raw input into the CLK domain.
module gf180mcu_fd_sc_mcu7t5v0__dbnc_sync
    import gf180mcu_fd_sc_mcu7t5v0__dbnc_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_s
);

    localparam int N = clamp_range(STAGES, SYNC_MIN, SYNC_MAX);

    logic [N-1:0] r_sync;

    // Shift chain; bit 0 samples the asynchronous input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {N{RST_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_s = r_sync[N-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_filt.sv
// Synchronizing glitch/debounce filter: Z toggles only after the synchronized
// input has differed from Z for FILT_LEN consecutive enabled clocks.
// Optional edge pulses: define GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN. Timing arcs unless FUNCTIONAL.
module gf180mcu_fd_sc_mcu7t5v0__dbnc_filt
    import gf180mcu_fd_sc_mcu7t5v0__dbnc_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 8,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RN,
    input  logic I,
    input  logic EN,
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN
    output logic RISE,
    output logic FALL,
`endif
    output logic Z
);

    localparam int               FILT_N   = clamp_range(FILT_LEN, 1, FILT_MAX);
    localparam int               CNT_W    = cnt_width(FILT_N);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FILT_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    logic             w_diff;
    dbnc_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_z;

    gf180mcu_fd_sc_mcu7t5v0__dbnc_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RN),
        .i_d     (I),
        .o_s     (w_s)
    );

    assign w_diff = (w_s != r_z);

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN
    logic r_rise;
    logic r_fall;
    assign RISE = r_rise;
    assign FALL = r_fall;
`endif

    // Qualification FSM; EN drop and glitch end both take priority over terminal count.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_z     <= RST_VAL;
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
`endif
        end else begin
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
`endif
            case (r_state)
                ST_STABLE: begin
                    if (EN && w_diff) begin
                        if (FILT_N == 1) begin
                            r_z    <= ~r_z;
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN
                            r_rise <= ~r_z;
                            r_fall <= r_z;
`endif
                        end else begin
                            r_state <= ST_QUAL;
                            r_cnt   <= CNT_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_QUAL: begin
                    if (!EN || !w_diff) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_TERM) begin
                        r_z     <= ~r_z;
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__DBNC_EDGE_OUT_EN
                        r_rise  <= ~r_z;
                        r_fall  <= r_z;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Z = r_z;

`ifndef FUNCTIONAL
    specify
        (posedge CLK => (Z : I)) = (1, 1);
        (negedge RN => (Z : RN)) = (1, 1);
        $setuphold(posedge CLK, EN, 1, 1);
        $recrem(posedge RN, posedge CLK, 1, 1);
    endspecify
`endif

endmodule
